// File: rtl/ami_req_in_queue_pkg.sv
// AMI request-bus layout shared by the request input queue and its consumers.
package ami_pkg;

    localparam int AMI_ADDR_WIDTH        = 64;
    localparam int AMI_DATA_WIDTH        = 576;
    localparam int AMI_REQ_SIZE_WIDTH    = 6;
    localparam int AMI_REQUEST_BUS_WIDTH = 648;

    localparam int AMI_REQ_VALID_BIT = 0;
    localparam int AMI_REQ_WR_BIT    = 1;
    localparam int AMI_REQ_ADDR_LO   = 2;
    localparam int AMI_REQ_ADDR_HI   = 65;
    localparam int AMI_REQ_DATA_LO   = 66;
    localparam int AMI_REQ_DATA_HI   = 641;
    localparam int AMI_REQ_SIZE_LO   = 642;
    localparam int AMI_REQ_SIZE_HI   = 647;

    // Packed MSB-first, so the member order mirrors the bit ranges above.
    typedef struct packed {
        logic [AMI_REQ_SIZE_WIDTH-1:0] size;
        logic [AMI_DATA_WIDTH-1:0]     data;
        logic [AMI_ADDR_WIDTH-1:0]     addr;
        logic                          is_write;
        logic                          valid;
    } ami_req_t;

    // 8-byte sector within a 64-byte block.
    function automatic logic [2:0] ami_sector(input logic [AMI_ADDR_WIDTH-1:0] addr);
        return addr[5:3];
    endfunction

endpackage

// File: rtl/ami_req_in_queue_if.sv
// Producer/consumer view of the request input queue.
interface ami_req_in_queue_if
    import ami_pkg::*;
#(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AMI_REQUEST_BUS_WIDTH-1:0] req_in;
    logic                             req_in_grant;
    logic [AMI_REQUEST_BUS_WIDTH-1:0] req_out;
    logic                             req_out_deq;
    logic [AMI_ADDR_WIDTH-1:0]        req_out_addr;
    logic [2:0]                       req_out_sector;
    logic                             req_out_wr;
    logic [CW-1:0]                    count;
    logic                             empty;
    logic                             full;
    logic                             almost_full;
    logic                             err_underflow;

    modport master (
        output req_in, req_out_deq,
        input  req_in_grant, req_out, req_out_addr, req_out_sector, req_out_wr,
               count, empty, full, almost_full, err_underflow
    );

    modport slave (
        input  req_in, req_out_deq,
        output req_in_grant, req_out, req_out_addr, req_out_sector, req_out_wr,
               count, empty, full, almost_full, err_underflow
    );
endinterface

// File: rtl/ami_req_in_queue_fifo_mem.sv
// Queue storage: one write port, asynchronous read; contents survive reset.
module ami_fifo_mem
    import ami_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = AMI_REQUEST_BUS_WIDTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ami_req_in_queue.sv
// First-word-fall-through request queue between the AMI request bus and the block buffer.
module ami_req_in_queue
    import ami_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    ami_req_in_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);

    // Pointers carry an extra wrap bit so wr - rd is the occupancy, 0..DEPTH.
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] w_wr_nxt, w_rd_nxt, w_count_nxt;
    logic        r_empty, r_full, r_af, r_underflow;
    logic        w_enq, w_deq;
    ami_req_t    w_head;

    // No grant while reset is held, so nothing is accepted into a queue being cleared.
    assign w_enq = q.req_in[AMI_REQ_VALID_BIT] & ~r_full & rst_n;
    assign w_deq = q.req_out_deq & ~r_empty;

    assign w_wr_nxt    = w_enq ? r_wr_ptr + PTR_ONE : r_wr_ptr;
    assign w_rd_nxt    = w_deq ? r_rd_ptr + PTR_ONE : r_rd_ptr;
    assign w_count_nxt = w_wr_nxt - w_rd_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_af        <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_empty  <= (w_count_nxt == '0);
            r_full   <= (w_count_nxt == FULL_CNT);
            r_af     <= (w_count_nxt >= AF_CNT);
            if (q.req_out_deq && r_empty) r_underflow <= 1'b1;
        end
    end

    ami_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (AMI_REQUEST_BUS_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (q.req_in),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_head)
    );

    assign q.req_in_grant   = w_enq;
    assign q.req_out        = {w_head[AMI_REQUEST_BUS_WIDTH-1:1], w_head.valid & ~r_empty};
    assign q.req_out_addr   = w_head.addr;
    assign q.req_out_sector = ami_sector(w_head.addr);
    assign q.req_out_wr     = w_head.is_write & ~r_empty;
    assign q.count          = r_wr_ptr - r_rd_ptr;
    assign q.empty          = r_empty;
    assign q.full           = r_full;
    assign q.almost_full    = r_af;
    assign q.err_underflow  = r_underflow;
endmodule

// File: tb/tb_ami_req_in_queue.sv
// Directed bench for the AMI request input queue (DEPTH 4, AF_THRESH 3).
module tb_ami_req_in_queue;
    import ami_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ami_req_in_queue_if #(.DEPTH(4)) q_if ();

    ami_req_in_queue #(.DEPTH(4), .AF_THRESH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AMI_REQUEST_BUS_WIDTH-1:0] mk_req(
        input logic [63:0] addr, input logic wr, input logic [5:0] size);
        ami_req_t r;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.data     = {9{addr ^ 64'hA5A5_0000_0000_0000}};
        r.size     = size;
        return r;
    endfunction

    // One active edge, returning just after the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q_if.req_in = '0;
        q_if.req_out_deq = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (q_if.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", q_if.empty); end
        checks++; if (q_if.req_out[0] !== 1'b0) begin errors++; $display("FAIL reset_req_out_valid got=%b exp=0", q_if.req_out[0]); end
        checks++; if (q_if.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", q_if.count); end
        checks++; if (q_if.req_in_grant !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0", q_if.req_in_grant); end
        checks++; if ({q_if.full, q_if.almost_full, q_if.err_underflow} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {q_if.full, q_if.almost_full, q_if.err_underflow}); end
    endtask

    task automatic test_single();
        q_if.req_in = mk_req(64'h1028, 1'b1, 6'd8);
        #1;
        checks++; if (q_if.req_in_grant !== 1'b1) begin errors++; $display("FAIL single_grant got=%b exp=1", q_if.req_in_grant); end
        checks++; if (q_if.req_out[0] !== 1'b0) begin errors++; $display("FAIL single_no_bypass got=%b exp=0", q_if.req_out[0]); end
        tick();
        q_if.req_in = '0;
        #1;
        checks++; if (q_if.req_out_addr !== 64'h1028) begin errors++; $display("FAIL single_addr got=%h exp=1028", q_if.req_out_addr); end
        checks++; if (q_if.req_out_sector !== 3'd5) begin errors++; $display("FAIL single_sector got=%0d exp=5", q_if.req_out_sector); end
        checks++; if (q_if.req_out_wr !== 1'b1) begin errors++; $display("FAIL single_wr got=%b exp=1", q_if.req_out_wr); end
        checks++; if (q_if.count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", q_if.count); end
        checks++; if (q_if.req_out[AMI_REQ_SIZE_HI:AMI_REQ_SIZE_LO] !== 6'd8) begin
            errors++; $display("FAIL single_size got=%0d exp=8", q_if.req_out[AMI_REQ_SIZE_HI:AMI_REQ_SIZE_LO]); end
        checks++; if (q_if.req_out[0] !== 1'b1 || q_if.empty !== 1'b0) begin
            errors++; $display("FAIL single_valid got=%b/%b exp=1/0", q_if.req_out[0], q_if.empty); end
        q_if.req_out_deq = 1'b1;
        tick();
        q_if.req_out_deq = 1'b0;
        #1;
        checks++; if (q_if.empty !== 1'b1 || q_if.count !== 3'd0) begin
            errors++; $display("FAIL single_deq_empty got=%b/%0d exp=1/0", q_if.empty, q_if.count); end
        checks++; if (q_if.req_out[0] !== 1'b0 || q_if.req_out_wr !== 1'b0) begin
            errors++; $display("FAIL single_deq_outs got=%b/%b exp=0/0", q_if.req_out[0], q_if.req_out_wr); end
    endtask

    task automatic test_fill();
        logic [63:0] exp_addr [4];
        exp_addr[0] = 64'h00; exp_addr[1] = 64'h40; exp_addr[2] = 64'h80; exp_addr[3] = 64'hC0;
        for (int i = 0; i < 4; i++) begin
            q_if.req_in = mk_req(exp_addr[i], 1'b0, 6'd4);
            #1;
            checks++; if (q_if.req_in_grant !== 1'b1) begin errors++; $display("FAIL fill_grant_%0d got=%b exp=1", i, q_if.req_in_grant); end
            tick();
            checks++; if (q_if.count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count_%0d got=%0d exp=%0d", i, q_if.count, i + 1); end
            checks++; if (q_if.almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_af_%0d got=%b exp=%b", i, q_if.almost_full, i >= 2); end
            checks++; if (q_if.full !== (i == 3)) begin errors++; $display("FAIL fill_full_%0d got=%b exp=%b", i, q_if.full, i == 3); end
        end
        q_if.req_in = mk_req(64'h100, 1'b1, 6'd4);
        #1;
        checks++; if (q_if.req_in_grant !== 1'b0) begin errors++; $display("FAIL fill_grant_5th got=%b exp=0", q_if.req_in_grant); end
        tick();
        checks++; if (q_if.count !== 3'd4) begin errors++; $display("FAIL fill_hold_count got=%0d exp=4", q_if.count); end
        // deq while full: grant stays low this cycle, the slot frees next cycle
        q_if.req_out_deq = 1'b1;
        #1;
        checks++; if (q_if.req_in_grant !== 1'b0) begin errors++; $display("FAIL fill_grant_full_deq got=%b exp=0", q_if.req_in_grant); end
        checks++; if (q_if.req_out_addr !== 64'h00) begin errors++; $display("FAIL fill_drain_0 got=%h exp=0", q_if.req_out_addr); end
        tick();
        q_if.req_in = '0;
        for (int i = 1; i < 4; i++) begin
            #1;
            checks++; if (q_if.req_out_addr !== exp_addr[i] || q_if.req_out[0] !== 1'b1) begin
                errors++; $display("FAIL fill_drain_%0d got=%h/%b exp=%h/1", i, q_if.req_out_addr, q_if.req_out[0], exp_addr[i]); end
            tick();
        end
        q_if.req_out_deq = 1'b0;
        #1;
        checks++; if (q_if.empty !== 1'b1 || q_if.full !== 1'b0 || q_if.almost_full !== 1'b0) begin
            errors++; $display("FAIL fill_drained_flags got=%b%b%b exp=100", q_if.empty, q_if.full, q_if.almost_full); end
    endtask

    task automatic test_wrap();
        logic [63:0] model [$];
        logic [63:0] a;
        for (int i = 0; i < 2; i++) begin
            a = 64'h2000 + 64'(i) * 64'h40;
            q_if.req_in = mk_req(a, 1'b0, 6'd8);
            model.push_back(a);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            a = 64'h3000 + 64'(i) * 64'h48;
            q_if.req_in = mk_req(a, i[0], 6'd8);
            q_if.req_out_deq = 1'b1;
            #1;
            checks++; if (q_if.req_out_addr !== model[0]) begin errors++; $display("FAIL wrap_head_%0d got=%h exp=%h", i, q_if.req_out_addr, model[0]); end
            checks++; if (q_if.req_in_grant !== 1'b1) begin errors++; $display("FAIL wrap_grant_%0d got=%b exp=1", i, q_if.req_in_grant); end
            tick();
            void'(model.pop_front());
            model.push_back(a);
            checks++; if (q_if.count !== 3'd2) begin errors++; $display("FAIL wrap_count_%0d got=%0d exp=2", i, q_if.count); end
        end
        q_if.req_in = '0;
        while (model.size() > 0) begin
            #1;
            checks++; if (q_if.req_out_addr !== model[0]) begin errors++; $display("FAIL wrap_drain got=%h exp=%h", q_if.req_out_addr, model[0]); end
            void'(model.pop_front());
            tick();
        end
        q_if.req_out_deq = 1'b0;
        #1;
        checks++; if (q_if.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", q_if.empty); end
    endtask

    task automatic test_underflow();
        q_if.req_out_deq = 1'b1;
        tick();
        q_if.req_out_deq = 1'b0;
        #1;
        checks++; if (q_if.err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got=%b exp=1", q_if.err_underflow); end
        checks++; if (q_if.count !== 3'd0 || q_if.empty !== 1'b1) begin
            errors++; $display("FAIL underflow_ptrs got=%0d/%b exp=0/1", q_if.count, q_if.empty); end
        q_if.req_in = mk_req(64'h5558, 1'b1, 6'd2);
        tick();
        q_if.req_in = '0;
        #1;
        checks++; if (q_if.req_out_addr !== 64'h5558 || q_if.req_out_sector !== 3'd3 || q_if.count !== 3'd1) begin
            errors++; $display("FAIL underflow_after_enq got=%h/%0d/%0d exp=5558/3/1", q_if.req_out_addr, q_if.req_out_sector, q_if.count); end
        q_if.req_out_deq = 1'b1;
        tick();
        q_if.req_out_deq = 1'b0;
        tick();
        checks++; if (q_if.err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", q_if.err_underflow); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            q_if.req_in = mk_req(64'h9000 + 64'(i) * 64'h8, 1'b1, 6'd8);
            tick();
        end
        q_if.req_in = '0;
        #1;
        checks++; if (q_if.count !== 3'd3) begin errors++; $display("FAIL areset_pre_count got=%0d exp=3", q_if.count); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (q_if.empty !== 1'b1 || q_if.req_out[0] !== 1'b0) begin
            errors++; $display("FAIL areset_immediate got=%b/%b exp=1/0", q_if.empty, q_if.req_out[0]); end
        checks++; if (q_if.count !== 3'd0 || q_if.err_underflow !== 1'b0 || q_if.almost_full !== 1'b0) begin
            errors++; $display("FAIL areset_state got=%0d/%b/%b exp=0/0/0", q_if.count, q_if.err_underflow, q_if.almost_full); end
        @(negedge clk);
        rst_n = 1'b1;
        q_if.req_in = mk_req(64'h2A8, 1'b0, 6'd8);
        tick();
        q_if.req_in = '0;
        #1;
        checks++; if (q_if.req_out_addr !== 64'h2A8 || q_if.count !== 3'd1 || q_if.req_out_wr !== 1'b0) begin
            errors++; $display("FAIL areset_first_after got=%h/%0d/%b exp=2a8/1/0", q_if.req_out_addr, q_if.count, q_if.req_out_wr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        q_if.req_in = '0;
        q_if.req_out_deq = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_underflow();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout exceeded 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
